// File: rtl/hairpin_loop.sv
// hairpin_loop: sits between the adapter and the CMAC.
//   Pass-through: adapter -> CMAC TX, CMAC RX -> adapter, unmodified.
//   Loopback:     CMAC RX -> CMAC TX, with MAC addresses (and optionally IPv4
//                 addresses) swapped on the first beat of every packet.
// Mode changes only when neither input is inside a packet. Every output
// stream is driven from a 2-entry register FIFO.
//
// Ports:
//   cmac_clk, rstn        clock, asynchronous active-low reset
//   loop_en               requested mode (1 = loopback)
//   loop_active           current mode
//   loop_pkts             count of looped packets (wraps)
//   s_axis_adap_*         from adapter         (tready out)
//   m_axis_cmac_*         to CMAC TX           (tready in)
//   s_axis_cmac_*         from CMAC RX         (tready out)
//   m_axis_adap_*         to adapter           (tready in)

// Two-entry FIFO: head register drives the output, skid register catches
// the beat accepted while the head is stalled. full = skid occupied.
module hairpin_loop_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         full
);
    logic         head_v_q;
    logic         skid_v_q;
    logic [W-1:0] head_q;
    logic [W-1:0] skid_q;
    logic         pop;

    assign pop = head_v_q && pop_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            head_q   <= '0;
            skid_q   <= '0;
        end else if (skid_v_q) begin
            // Full: upstream tready was already low, so only a pop can happen.
            if (pop) begin
                head_q   <= skid_q;
                skid_v_q <= 1'b0;
            end
        end else if (head_v_q) begin
            if (push && pop) begin
                head_q <= push_data;
            end else if (push) begin
                skid_q   <= push_data;
                skid_v_q <= 1'b1;
            end else if (pop) begin
                head_v_q <= 1'b0;
            end
        end else if (push) begin
            head_q   <= push_data;
            head_v_q <= 1'b1;
        end
    end

    assign out_valid = head_v_q;
    assign out_data  = head_q;
    assign full      = skid_v_q;
endmodule

module hairpin_loop #(
    parameter int DATA_W  = 512,
    parameter int SWAP_IP = 0
) (
    input  logic                cmac_clk,
    input  logic                rstn,
    input  logic                loop_en,
    output logic                loop_active,
    output logic [31:0]         loop_pkts,

    input  logic                s_axis_adap_tvalid,
    input  logic [DATA_W-1:0]   s_axis_adap_tdata,
    input  logic [DATA_W/8-1:0] s_axis_adap_tkeep,
    input  logic                s_axis_adap_tlast,
    input  logic                s_axis_adap_tuser_err,
    output logic                s_axis_adap_tready,

    output logic                m_axis_cmac_tvalid,
    output logic [DATA_W-1:0]   m_axis_cmac_tdata,
    output logic [DATA_W/8-1:0] m_axis_cmac_tkeep,
    output logic                m_axis_cmac_tlast,
    output logic                m_axis_cmac_tuser_err,
    input  logic                m_axis_cmac_tready,

    input  logic                s_axis_cmac_tvalid,
    input  logic [DATA_W-1:0]   s_axis_cmac_tdata,
    input  logic [DATA_W/8-1:0] s_axis_cmac_tkeep,
    input  logic                s_axis_cmac_tlast,
    input  logic                s_axis_cmac_tuser_err,
    output logic                s_axis_cmac_tready,

    output logic                m_axis_adap_tvalid,
    output logic [DATA_W-1:0]   m_axis_adap_tdata,
    output logic [DATA_W/8-1:0] m_axis_adap_tkeep,
    output logic                m_axis_adap_tlast,
    output logic                m_axis_adap_tuser_err,
    input  logic                m_axis_adap_tready
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int PW     = DATA_W + KEEP_W + 2;

    typedef enum logic {
        MODE_PASS = 1'b0,
        MODE_LOOP = 1'b1
    } mode_t;

    mode_t           mode_q;
    mode_t           mode_nxt;
    logic            rdy_q;
    logic            adap_in_pkt_q;
    logic            cmac_in_pkt_q;
    logic            adap_in_pkt_nxt;
    logic            cmac_in_pkt_nxt;
    logic            adap_acc;
    logic            cmac_acc;
    logic            cmac_fifo_full;
    logic            adap_fifo_full;
    logic            cmac_push;
    logic            adap_push;
    logic [PW-1:0]   cmac_push_data;
    logic [PW-1:0]   adap_push_data;
    logic [PW-1:0]   cmac_out_data;
    logic [PW-1:0]   adap_out_data;
    logic [DATA_W-1:0] mac_sw;
    logic [DATA_W-1:0] sop_data;
    logic [DATA_W-1:0] lb_tdata;

    // Holds all s_axis tready low until the first edge after reset release.
    always_ff @(posedge cmac_clk or negedge rstn) begin
        if (!rstn) rdy_q <= 1'b0;
        else       rdy_q <= 1'b1;
    end

    // Mode FSM: state register.
    always_ff @(posedge cmac_clk or negedge rstn) begin
        if (!rstn) mode_q <= MODE_PASS;
        else       mode_q <= mode_nxt;
    end

    // Mode FSM: next state, only at a boundary on both inputs.
    always_comb begin
        mode_nxt = mode_q;
        if (!adap_in_pkt_nxt && !cmac_in_pkt_nxt)
            mode_nxt = loop_en ? MODE_LOOP : MODE_PASS;
    end

    // Mode FSM: outputs.
    always_comb begin
        loop_active = (mode_q == MODE_LOOP);
    end

    // Ready depends only on registered FIFO state and mode.
    always_comb begin
        s_axis_adap_tready = rdy_q && !loop_active && !cmac_fifo_full;
        s_axis_cmac_tready = rdy_q && (loop_active ? !cmac_fifo_full : !adap_fifo_full);
    end

    assign adap_acc        = s_axis_adap_tvalid && s_axis_adap_tready;
    assign cmac_acc        = s_axis_cmac_tvalid && s_axis_cmac_tready;
    assign adap_in_pkt_nxt = adap_acc ? !s_axis_adap_tlast : adap_in_pkt_q;
    assign cmac_in_pkt_nxt = cmac_acc ? !s_axis_cmac_tlast : cmac_in_pkt_q;

    always_ff @(posedge cmac_clk or negedge rstn) begin
        if (!rstn) begin
            adap_in_pkt_q <= 1'b0;
            cmac_in_pkt_q <= 1'b0;
        end else begin
            adap_in_pkt_q <= adap_in_pkt_nxt;
            cmac_in_pkt_q <= cmac_in_pkt_nxt;
        end
    end

    // Destination <-> source MAC exchange (bytes 0-5 vs 6-11).
    always_comb begin
        mac_sw = s_axis_cmac_tdata;
        for (int unsigned i = 0; i < 6; i++) begin
            mac_sw[8*i +: 8]     = s_axis_cmac_tdata[8*(i+6) +: 8];
            mac_sw[8*(i+6) +: 8] = s_axis_cmac_tdata[8*i +: 8];
        end
    end

    generate
        if (SWAP_IP != 0) begin : g_ip_swap
            // IPv4 only (ethertype 0x0800): bytes 26-29 vs 30-33.
            always_comb begin
                sop_data = mac_sw;
                if (s_axis_cmac_tdata[8*12 +: 8] == 8'h08 &&
                    s_axis_cmac_tdata[8*13 +: 8] == 8'h00) begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        sop_data[8*(26+i) +: 8] = s_axis_cmac_tdata[8*(30+i) +: 8];
                        sop_data[8*(30+i) +: 8] = s_axis_cmac_tdata[8*(26+i) +: 8];
                    end
                end
            end
        end else begin : g_no_ip_swap
            assign sop_data = mac_sw;
        end
    endgenerate

    assign lb_tdata = cmac_in_pkt_q ? s_axis_cmac_tdata : sop_data;

    // Routing: beats accepted on a mode-change edge use the old mode_q.
    always_comb begin
        if (loop_active) begin
            cmac_push      = cmac_acc;
            cmac_push_data = {lb_tdata, s_axis_cmac_tkeep,
                              s_axis_cmac_tlast, s_axis_cmac_tuser_err};
            adap_push      = 1'b0;
        end else begin
            cmac_push      = adap_acc;
            cmac_push_data = {s_axis_adap_tdata, s_axis_adap_tkeep,
                              s_axis_adap_tlast, s_axis_adap_tuser_err};
            adap_push      = cmac_acc;
        end
        adap_push_data = {s_axis_cmac_tdata, s_axis_cmac_tkeep,
                          s_axis_cmac_tlast, s_axis_cmac_tuser_err};
    end

    always_ff @(posedge cmac_clk or negedge rstn) begin
        if (!rstn)
            loop_pkts <= '0;
        else if (loop_active && cmac_acc && s_axis_cmac_tlast)
            loop_pkts <= loop_pkts + 32'd1;
    end

    hairpin_loop_fifo #(.W(PW)) u_cmac_fifo (
        .clk       (cmac_clk),
        .rst_n     (rstn),
        .push      (cmac_push),
        .push_data (cmac_push_data),
        .pop_ready (m_axis_cmac_tready),
        .out_valid (m_axis_cmac_tvalid),
        .out_data  (cmac_out_data),
        .full      (cmac_fifo_full)
    );

    hairpin_loop_fifo #(.W(PW)) u_adap_fifo (
        .clk       (cmac_clk),
        .rst_n     (rstn),
        .push      (adap_push),
        .push_data (adap_push_data),
        .pop_ready (m_axis_adap_tready),
        .out_valid (m_axis_adap_tvalid),
        .out_data  (adap_out_data),
        .full      (adap_fifo_full)
    );

    assign {m_axis_cmac_tdata, m_axis_cmac_tkeep,
            m_axis_cmac_tlast, m_axis_cmac_tuser_err} = cmac_out_data;
    assign {m_axis_adap_tdata, m_axis_adap_tkeep,
            m_axis_adap_tlast, m_axis_adap_tuser_err} = adap_out_data;
endmodule

// File: tb/tb_hairpin_loop.sv
module tb_hairpin_loop;
    logic         clk;
    logic         rstn;
    logic         loop_en;
    logic         av, al, ae, cv, cl, ce, mcr, mar;
    logic [511:0] ad, cd;
    logic [63:0]  ak, ck;

    logic         adr, cdr, mcv, mcl, mce, mav, mal, mae, act;
    logic [511:0] mcd, mad;
    logic [63:0]  mck, mak;
    logic [31:0]  pkts;

    logic         d0_adr, d0_cdr, d0_mcv, d0_mcl, d0_mce, d0_mav, d0_mal, d0_mae, d0_act;
    logic [511:0] d0_mcd, d0_mad;
    logic [63:0]  d0_mck, d0_mak;
    logic [31:0]  d0_pkts;

    int n_checks = 0;
    int n_errors = 0;

    hairpin_loop #(.DATA_W(512), .SWAP_IP(1)) dut (
        .cmac_clk(clk), .rstn(rstn), .loop_en(loop_en),
        .loop_active(act), .loop_pkts(pkts),
        .s_axis_adap_tvalid(av), .s_axis_adap_tdata(ad), .s_axis_adap_tkeep(ak),
        .s_axis_adap_tlast(al), .s_axis_adap_tuser_err(ae), .s_axis_adap_tready(adr),
        .m_axis_cmac_tvalid(mcv), .m_axis_cmac_tdata(mcd), .m_axis_cmac_tkeep(mck),
        .m_axis_cmac_tlast(mcl), .m_axis_cmac_tuser_err(mce), .m_axis_cmac_tready(mcr),
        .s_axis_cmac_tvalid(cv), .s_axis_cmac_tdata(cd), .s_axis_cmac_tkeep(ck),
        .s_axis_cmac_tlast(cl), .s_axis_cmac_tuser_err(ce), .s_axis_cmac_tready(cdr),
        .m_axis_adap_tvalid(mav), .m_axis_adap_tdata(mad), .m_axis_adap_tkeep(mak),
        .m_axis_adap_tlast(mal), .m_axis_adap_tuser_err(mae), .m_axis_adap_tready(mar)
    );

    hairpin_loop #(.DATA_W(512), .SWAP_IP(0)) dut0 (
        .cmac_clk(clk), .rstn(rstn), .loop_en(loop_en),
        .loop_active(d0_act), .loop_pkts(d0_pkts),
        .s_axis_adap_tvalid(av), .s_axis_adap_tdata(ad), .s_axis_adap_tkeep(ak),
        .s_axis_adap_tlast(al), .s_axis_adap_tuser_err(ae), .s_axis_adap_tready(d0_adr),
        .m_axis_cmac_tvalid(d0_mcv), .m_axis_cmac_tdata(d0_mcd), .m_axis_cmac_tkeep(d0_mck),
        .m_axis_cmac_tlast(d0_mcl), .m_axis_cmac_tuser_err(d0_mce), .m_axis_cmac_tready(mcr),
        .s_axis_cmac_tvalid(cv), .s_axis_cmac_tdata(cd), .s_axis_cmac_tkeep(ck),
        .s_axis_cmac_tlast(cl), .s_axis_cmac_tuser_err(ce), .s_axis_cmac_tready(d0_cdr),
        .m_axis_adap_tvalid(d0_mav), .m_axis_adap_tdata(d0_mad), .m_axis_adap_tkeep(d0_mak),
        .m_axis_adap_tlast(d0_mal), .m_axis_adap_tuser_err(d0_mae), .m_axis_adap_tready(mar)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string        name;
        logic         le;
        logic         av;
        logic [511:0] ad;
        logic         al;
        logic         cv;
        logic [511:0] cd;
        logic         cl;
        logic [63:0]  ck;
        logic         ce;
        logic         x_mcv;
        logic [511:0] x_mcd;
        logic         x_mcl;
        logic [63:0]  x_mck;
        logic         x_mce;
        logic         x_mav;
        logic [511:0] x_mad;
        logic         x_mal;
        logic [63:0]  x_mak;
        logic         x_mae;
        logic         x_act;
        logic [31:0]  x_pkts;
        logic         x_adr;
        logic         x_cdr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk1(input string name, input logic a, input logic e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got %b required %b", name, a, e);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", name, a, e);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] a, input logic [63:0] e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, a, e);
        end
    endtask

    task automatic chk512(input string name, input logic [511:0] a, input logic [511:0] e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Byte n of the frame lives at d[8n+7:8n]; multi-byte fields are big-endian.
    function automatic logic [511:0] build_frame(input logic [47:0] dst, input logic [47:0] src,
                                                 input logic [15:0] et, input logic [31:0] ipa,
                                                 input logic [31:0] ipb, input logic [7:0] fb);
        logic [511:0] d;
        for (int i = 0; i < 64; i++) d[8*i +: 8] = fb ^ 8'(i);
        for (int i = 0; i < 6; i++) begin
            d[8*i +: 8]     = dst[8*(5-i) +: 8];
            d[8*(6+i) +: 8] = src[8*(5-i) +: 8];
        end
        d[8*12 +: 8] = et[15:8];
        d[8*13 +: 8] = et[7:0];
        for (int i = 0; i < 4; i++) begin
            d[8*(26+i) +: 8] = ipa[8*(3-i) +: 8];
            d[8*(30+i) +: 8] = ipb[8*(3-i) +: 8];
        end
        return d;
    endfunction

    function automatic logic [511:0] pat(input int k);
        return build_frame({40'h02_0000_0000, 8'(k)}, {40'h04_0000_0000, 8'(k)},
                           16'h0800, 32'hC0A8_0100 | 32'(k), 32'hC0A8_0200, 8'(k));
    endfunction

    localparam logic [47:0] MAC_D = 48'h11_22_33_44_55_66;
    localparam logic [47:0] MAC_S = 48'hAA_BB_CC_DD_EE_FF;
    localparam logic [31:0] IP_A  = 32'h0A_00_00_01;
    localparam logic [31:0] IP_B  = 32'h0A_00_00_02;

    logic [511:0] A, B, J, Z, F0, F0S, P1, P2, IP4, IP4S1, IP4S0;
    logic [63:0]  KA, KP;
    int tx, rx;
    logic acc, pop;

    initial begin
        KA  = '1;
        KP  = 64'h00FF_FF00_0F0F_F0F0;
        Z   = '0;
        A   = build_frame(48'h0A0B0C0D0E0F, 48'h101112131415, 16'h0800, IP_A, IP_B, 8'hA5);
        B   = build_frame(48'h202122232425, 48'h262728292A2B, 16'h0800, IP_B, IP_A, 8'h5A);
        J   = build_frame(48'hDEADBEEF0001, 48'hDEADBEEF0002, 16'h0800, IP_A, IP_B, 8'hEE);
        F0  = build_frame(MAC_D, MAC_S, 16'h86DD, IP_A, IP_B, 8'h30);
        F0S = build_frame(MAC_S, MAC_D, 16'h86DD, IP_A, IP_B, 8'h30);
        P1  = build_frame(48'h010203040506, 48'h0708090A0B0C, 16'h0800, 32'hC0A80001, 32'hC0A80002, 8'h31);
        P2  = build_frame(48'h0D0E0F101112, 48'h131415161718, 16'h0800, 32'hC0A80003, 32'hC0A80004, 8'h32);
        IP4   = build_frame(MAC_D, MAC_S, 16'h0800, IP_A, IP_B, 8'h50);
        IP4S1 = build_frame(MAC_S, MAC_D, 16'h0800, IP_B, IP_A, 8'h50);
        IP4S0 = build_frame(MAC_S, MAC_D, 16'h0800, IP_A, IP_B, 8'h50);

        //          name        le    av    ad al    cv    cd  cl    ck  ce   | mcv  mcd  mcl  mck ce   | mav  mad  mal  mak ae   | act  pkts   adr   cdr
        vecs[0] = '{"pt_both",   1'b0, 1'b1, A, 1'b1, 1'b1, B,  1'b1, KP, 1'b1, 1'b1, A,   1'b1, KA, 1'b0, 1'b1, B,  1'b1, KP, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1};
        vecs[1] = '{"pt_idle",   1'b0, 1'b0, Z, 1'b0, 1'b0, Z,  1'b0, KA, 1'b0, 1'b0, Z,   1'b0, KA, 1'b0, 1'b0, Z,  1'b0, KA, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1};
        vecs[2] = '{"loop_req",  1'b1, 1'b0, Z, 1'b0, 1'b0, Z,  1'b0, KA, 1'b0, 1'b0, Z,   1'b0, KA, 1'b0, 1'b0, Z,  1'b0, KA, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1};
        vecs[3] = '{"mac_b0",    1'b1, 1'b1, J, 1'b0, 1'b1, F0, 1'b0, KA, 1'b0, 1'b1, F0S, 1'b0, KA, 1'b0, 1'b0, Z,  1'b0, KA, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1};
        vecs[4] = '{"mac_b1",    1'b1, 1'b1, J, 1'b0, 1'b1, P1, 1'b0, KA, 1'b0, 1'b1, P1,  1'b0, KA, 1'b0, 1'b0, Z,  1'b0, KA, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1};
        vecs[5] = '{"mac_b2",    1'b1, 1'b1, J, 1'b0, 1'b1, P2, 1'b1, KP, 1'b1, 1'b1, P2,  1'b1, KP, 1'b1, 1'b0, Z,  1'b0, KA, 1'b0, 1'b1, 32'd1, 1'b0, 1'b1};
        vecs[6] = '{"loop_idle", 1'b1, 1'b0, Z, 1'b0, 1'b0, Z,  1'b0, KA, 1'b0, 1'b0, Z,   1'b0, KA, 1'b0, 1'b0, Z,  1'b0, KA, 1'b0, 1'b1, 32'd1, 1'b0, 1'b1};
        vecs[7] = '{"pass_req",  1'b0, 1'b0, Z, 1'b0, 1'b0, Z,  1'b0, KA, 1'b0, 1'b0, Z,   1'b0, KA, 1'b0, 1'b0, Z,  1'b0, KA, 1'b0, 1'b0, 32'd1, 1'b1, 1'b1};
        vecs[8] = '{"pt_cmac",   1'b0, 1'b0, Z, 1'b0, 1'b1, P1, 1'b1, KA, 1'b0, 1'b0, Z,   1'b0, KA, 1'b0, 1'b1, P1, 1'b1, KA, 1'b0, 1'b0, 32'd1, 1'b1, 1'b1};
        vecs[9] = '{"pt_idle2",  1'b0, 1'b0, Z, 1'b0, 1'b0, Z,  1'b0, KA, 1'b0, 1'b0, Z,   1'b0, KA, 1'b0, 1'b0, Z,  1'b0, KA, 1'b0, 1'b0, 32'd1, 1'b1, 1'b1};

        // Reset state
        rstn = 1'b0; loop_en = 1'b0;
        av = 1'b0; ad = '0; ak = KA; al = 1'b0; ae = 1'b0;
        cv = 1'b0; cd = '0; ck = KA; cl = 1'b0; ce = 1'b0;
        mcr = 1'b1; mar = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_mcv", mcv, 1'b0);
        chk1("rst_mav", mav, 1'b0);
        chk1("rst_adr", adr, 1'b0);
        chk1("rst_cdr", cdr, 1'b0);
        chk1("rst_act", act, 1'b0);
        chk32("rst_pkts", pkts, 32'd0);
        chk512("rst_mcd", mcd, Z);
        chk512("rst_mad", mad, Z);
        chk64("rst_mck", mck, 64'd0);
        chk1("rst_mcl", mcl, 1'b0);
        rstn = 1'b1;
        #1;
        chk1("rel_adr_pre", adr, 1'b0);
        step();
        chk1("rel_adr", adr, 1'b1);
        chk1("rel_cdr", cdr, 1'b1);

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            loop_en = vecs[i].le;
            av = vecs[i].av; ad = vecs[i].ad; al = vecs[i].al; ak = KA; ae = 1'b0;
            cv = vecs[i].cv; cd = vecs[i].cd; cl = vecs[i].cl; ck = vecs[i].ck; ce = vecs[i].ce;
            mcr = 1'b1; mar = 1'b1;
            step();
            chk1({vecs[i].name, "_mcv"}, mcv, vecs[i].x_mcv);
            if (vecs[i].x_mcv) begin
                chk512({vecs[i].name, "_mcd"}, mcd, vecs[i].x_mcd);
                chk1({vecs[i].name, "_mcl"}, mcl, vecs[i].x_mcl);
                chk64({vecs[i].name, "_mck"}, mck, vecs[i].x_mck);
                chk1({vecs[i].name, "_mce"}, mce, vecs[i].x_mce);
            end
            chk1({vecs[i].name, "_mav"}, mav, vecs[i].x_mav);
            if (vecs[i].x_mav) begin
                chk512({vecs[i].name, "_mad"}, mad, vecs[i].x_mad);
                chk1({vecs[i].name, "_mal"}, mal, vecs[i].x_mal);
                chk64({vecs[i].name, "_mak"}, mak, vecs[i].x_mak);
                chk1({vecs[i].name, "_mae"}, mae, vecs[i].x_mae);
            end
            chk1({vecs[i].name, "_act"}, act, vecs[i].x_act);
            chk32({vecs[i].name, "_pkts"}, pkts, vecs[i].x_pkts);
            chk1({vecs[i].name, "_adr"}, adr, vecs[i].x_adr);
            chk1({vecs[i].name, "_cdr"}, cdr, vecs[i].x_cdr);
        end
        av = 1'b0; cv = 1'b0; ck = KA; ce = 1'b0;

        // Backpressure: m_axis_cmac_tready low for 5 cycles, 8-beat packet
        tx = 0; rx = 0;
        av = 1'b1; ad = pat(0); al = 1'b0;
        for (int c = 0; c < 40 && rx < 8; c++) begin
            mcr = (c >= 5);
            if (c >= 1 && c < 5) begin
                chk1("bp_stall_valid", mcv, 1'b1);
                chk512("bp_stall_data", mcd, pat(0));
            end
            if (c == 5) begin
                chk32("bp_accepted", 32'(tx), 32'd2);
                chk1("bp_tready_low", adr, 1'b0);
            end
            acc = av && adr;
            pop = mcv && mcr;
            if (pop) begin
                chk512("bp_order", mcd, pat(rx));
                chk1("bp_last", mcl, (rx == 7));
                rx++;
            end
            step();
            if (acc) tx++;
            av = (tx < 8);
            ad = pat(tx);
            al = (tx == 7);
        end
        chk32("bp_received", 32'(rx), 32'd8);
        av = 1'b0; al = 1'b0; mcr = 1'b1;
        step();

        // Mode change requested mid-packet on a 4-beat adap packet
        for (int k = 0; k < 4; k++) begin
            av = 1'b1; ad = pat(16 + k); al = (k == 3);
            loop_en = (k >= 1);
            step();
            chk1("mc_valid", mcv, 1'b1);
            chk512("mc_data", mcd, pat(16 + k));
            chk1("mc_act", act, (k == 3));
        end
        av = 1'b0; al = 1'b0;
        step();

        // Single-beat flood on both inputs still switches mode
        loop_en = 1'b0;
        av = 1'b1; ad = pat(32); al = 1'b1;
        cv = 1'b1; cd = F0; cl = 1'b1;
        step();
        chk1("flood_to_pass", act, 1'b0);
        chk32("flood_pkts1", pkts, 32'd2);
        loop_en = 1'b1;
        step();
        chk1("flood_to_loop", act, 1'b1);
        chk32("flood_pkts2", pkts, 32'd2);
        av = 1'b0; cv = 1'b0; al = 1'b0; cl = 1'b0;
        step();

        // IPv4 address swap (SWAP_IP=1) versus none (SWAP_IP=0)
        cv = 1'b1; cd = IP4; cl = 1'b1;
        step();
        chk1("ip_valid", mcv, 1'b1);
        chk512("ip_swap1", mcd, IP4S1);
        chk512("ip_swap0", d0_mcd, IP4S0);
        chk32("ip_pkts", pkts, 32'd3);
        cv = 1'b0; cl = 1'b0;
        step();

        // Reset mid-packet with both FIFOs full
        loop_en = 1'b0;
        step();
        chk1("rp_pass", act, 1'b0);
        mcr = 1'b0; mar = 1'b0;
        av = 1'b1; ad = pat(40); al = 1'b0;
        cv = 1'b1; cd = pat(41); cl = 1'b0;
        repeat (3) step();
        chk1("rp_adr_full", adr, 1'b0);
        chk1("rp_cdr_full", cdr, 1'b0);
        chk1("rp_mcv_full", mcv, 1'b1);
        chk1("rp_mav_full", mav, 1'b1);
        loop_en = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk1("rp_mcv", mcv, 1'b0);
        chk1("rp_mav", mav, 1'b0);
        chk512("rp_mcd", mcd, Z);
        chk1("rp_adr", adr, 1'b0);
        chk1("rp_cdr", cdr, 1'b0);
        chk32("rp_pkts", pkts, 32'd0);
        chk1("rp_act", act, 1'b0);
        #2 rstn = 1'b1;
        av = 1'b0;
        cv = 1'b1; cd = F0; cl = 1'b0;
        mcr = 1'b1; mar = 1'b1;
        step();
        chk1("rp_rel_cdr", cdr, 1'b1);
        chk1("rp_rel_adr", adr, 1'b0);
        chk1("rp_rel_act", act, 1'b1);
        chk1("rp_rel_mcv", mcv, 1'b0);
        step();
        chk1("rp_sop_valid", mcv, 1'b1);
        chk512("rp_sop_swap", mcd, F0S);
        chk32("rp_sop_pkts", pkts, 32'd0);
        cv = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
